// File: rtl/pc_seq_unit_pkg.sv
// Shared types and helpers for the PC sequencer.
package pc_seq_unit_pkg;

  localparam int PC_W_DEF = 32;

  // Why the PC moved this cycle.
  typedef enum logic [2:0] {
    CAUSE_SEQ,
    CAUSE_BR,
    CAUSE_RET,
    CAUSE_TRAP,
    CAUSE_HOLD
  } cause_e;

  // Mask that clears the low log2(inc) bits; inc is a power of two.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return ~(64'(inc) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_seq_unit_ras.sv
// Circular return-address stack: push, pop, or replace-top in one cycle.
// When full, a push overwrites the oldest entry and sets the sticky overflow.
module pc_ras #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            Proc_reset,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_din,
  output logic [PC_W-1:0] o_top,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] ONE_P = 1;
  localparam logic [PW:0]   ONE_C = 1;
  localparam logic [PW:0]   FULL_C = (PW+1)'(DEPTH);

  logic [PC_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_sp;
  logic [PW:0]     r_cnt;
  logic            r_ovf;
  logic [PW-1:0]   w_top_idx;
  logic [PW-1:0]   w_wr_idx;
  logic            w_pop;

  assign w_top_idx = r_sp - ONE_P;
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == FULL_C);
  assign o_ovf     = r_ovf;
  assign o_top     = r_mem[w_top_idx];
  assign w_pop     = i_pop & ~o_empty;
  // push+pop rewrites the current top instead of moving the pointer
  assign w_wr_idx  = w_pop ? w_top_idx : r_sp;

  // Entry storage; contents are only read while non-empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_din;
  end

  // Pointer, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge Proc_reset) begin
    if (Proc_reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_push && !w_pop) begin
      r_sp <= r_sp + ONE_P;
      if (o_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + ONE_C;
    end else if (w_pop && !i_push) begin
      r_sp  <= r_sp - ONE_P;
      r_cnt <= r_cnt - ONE_C;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: reset vector, redirects, trap, stall,
// single-step gating and return-address prediction via pc_ras.
module pc_seq_unit
  import pc_seq_unit_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEF,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          INC       = 4,
  parameter int          RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            Proc_reset,
  input  logic            rst,
  input  logic            Proc_run_en,
  input  logic            step_mode,
  input  logic            step_req,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic [PC_W-1:0] trap_vec,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_next_o,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            misalign_o
);

  localparam logic [PC_W-1:0] RV    = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);
  localparam logic [PC_W-1:0] MASK  = PC_W'(align_mask(INC));

  logic [PC_W-1:0] r_pc;
  logic            r_step_q;
  logic            r_mis;
  logic [PC_W-1:0] w_inc, w_raw, w_ras_top;
  logic            w_adv, w_trap, w_redir, w_mis, w_push, w_pop;
  cause_e          w_cause;

  assign w_inc  = r_pc + INC_V;
  assign w_adv  = Proc_run_en & ~stall & (~step_mode | (step_req & ~r_step_q));
  // trap only needs run enable; it overrides stall and step gating
  assign w_trap = Proc_run_en & trap;
  assign w_push = w_adv & ~w_trap & call;
  assign w_pop  = w_adv & ~w_trap & ret & ~ras_empty;

  // Select the next-PC source in priority order.
  always_comb begin
    w_cause = CAUSE_HOLD;
    w_raw   = r_pc;
    if (w_trap) begin
      w_cause = CAUSE_TRAP;
      w_raw   = trap_vec;
    end else if (w_adv) begin
      if (ret && !ras_empty) begin
        w_cause = CAUSE_RET;
        w_raw   = w_ras_top;
      end else if (br_taken || ret) begin
        // ret with an empty stack falls back to the ALU-computed target
        w_cause = CAUSE_BR;
        w_raw   = br_target;
      end else begin
        w_cause = CAUSE_SEQ;
        w_raw   = w_inc;
      end
    end
  end

  assign w_redir   = (w_cause == CAUSE_TRAP) | (w_cause == CAUSE_RET) | (w_cause == CAUSE_BR);
  assign w_mis     = w_redir & (|(w_raw & ~MASK));
  assign pc_next_o = w_redir ? (w_raw & MASK) : w_raw;
  assign pc_o      = r_pc;
  assign misalign_o = r_mis;

  // PC register, step edge history and misalign pulse.
  always_ff @(posedge clk or posedge Proc_reset) begin
    if (Proc_reset) begin
      r_pc     <= RV;
      r_step_q <= 1'b0;
      r_mis    <= 1'b0;
    end else if (rst) begin
      r_pc     <= RV;
      r_step_q <= 1'b0;
      r_mis    <= 1'b0;
    end else begin
      r_pc     <= pc_next_o;
      r_step_q <= step_req;
      r_mis    <= w_mis;
    end
  end

  pc_ras #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk        (clk),
    .Proc_reset (Proc_reset),
    .rst        (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_din      (w_inc),
    .o_top      (w_ras_top),
    .o_empty    (ras_empty),
    .o_full     (ras_full),
    .o_ovf      (ras_ovf)
  );

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: driver pushes model expectations,
// monitor pops and compares one cycle later.
module tb_pc_seq_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Proc_reset, rst, run, smode, sreq, stall, br, call, ret, trap;
  logic [31:0] bt, tv;
  logic [31:0] pc_o, pc_next_o;
  logic        ras_empty, ras_full, ras_ovf, mis;
  logic [7:0]  pc8, pcn8;
  logic        e8, f8, o8, m8;

  pc_seq_unit #(.PC_W(32), .RESET_VEC(32'h100), .INC(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .Proc_reset(Proc_reset), .rst(rst), .Proc_run_en(run),
    .step_mode(smode), .step_req(sreq), .stall(stall), .br_taken(br),
    .br_target(bt), .call(call), .ret(ret), .trap(trap), .trap_vec(tv),
    .pc_o(pc_o), .pc_next_o(pc_next_o), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .misalign_o(mis)
  );

  // 8-bit instance for wrap-around and reset-vector truncation
  pc_seq_unit #(.PC_W(8), .RESET_VEC(32'h1F0), .INC(4), .RAS_DEPTH(2)) dut8 (
    .clk(clk), .Proc_reset(Proc_reset), .rst(1'b0), .Proc_run_en(1'b1),
    .step_mode(1'b0), .step_req(1'b0), .stall(1'b0), .br_taken(1'b0),
    .br_target(8'h00), .call(1'b0), .ret(1'b0), .trap(1'b0), .trap_vec(8'h00),
    .pc_o(pc8), .pc_next_o(pcn8), .ras_empty(e8), .ras_full(f8),
    .ras_ovf(o8), .misalign_o(m8)
  );

  typedef struct {
    bit run, smode, sreq, stall, br, call, ret, trap, rst;
    logic [31:0] bt, tv;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    bit mis, emp, ful, ovf;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state: PC, stack as a queue (back = top), flags.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_ovf, m_sq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h100;
    m_ras.delete();
    m_ovf = 0;
    m_sq = 0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.run = 1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic [31:0] npc, tgt;
    bit adv, redir, mbit;
    @(negedge clk);
    run = s.run; smode = s.smode; sreq = s.sreq; stall = s.stall;
    br = s.br; call = s.call; ret = s.ret; trap = s.trap; rst = s.rst;
    bt = s.bt; tv = s.tv;
    #1;
    mbit = 0;
    if (s.rst) begin
      model_reset();
      npc = 32'h100;
    end else begin
      adv = s.run && !s.stall && (!s.smode || (s.sreq && !m_sq));
      redir = 0;
      tgt = '0;
      npc = m_pc;
      if (s.run && s.trap) begin
        redir = 1;
        tgt = s.tv;
      end else if (adv) begin
        npc = m_pc + 32'd4;
        if (s.ret && m_ras.size() > 0) begin
          redir = 1;
          tgt = m_ras[$];
          if (s.call) m_ras[$] = m_pc + 32'd4;
          else void'(m_ras.pop_back());
        end else begin
          if (s.call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) begin
              void'(m_ras.pop_front());
              m_ovf = 1;
            end
          end
          if (s.br || s.ret) begin
            redir = 1;
            tgt = s.bt;
          end
        end
      end
      if (redir) begin
        npc = tgt & 32'hFFFF_FFFC;
        mbit = (tgt[1:0] != 2'b00);
      end
      chk("pc_next", pc_next_o, npc);
      m_sq = s.sreq;
      m_pc = npc;
    end
    e.pc = npc;
    e.mis = mbit;
    e.emp = (m_ras.size() == 0);
    e.ful = (m_ras.size() == 4);
    e.ovf = m_ovf;
    q.push_back(e);
  endtask

  // Monitor: after each active edge, compare registered outputs to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_o", pc_o, e.pc);
        chk("misalign", 32'(mis), 32'(e.mis));
        chk("ras_empty", 32'(ras_empty), 32'(e.emp));
        chk("ras_full", 32'(ras_full), 32'(e.ful));
        chk("ras_ovf", 32'(ras_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    logic [7:0] ev;
    Proc_reset = 1'b1;
    rst = 0; run = 1; smode = 0; sreq = 0; stall = 0;
    br = 0; call = 0; ret = 0; trap = 0; bt = '0; tv = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_mis", 32'(mis), 32'd0);
    Proc_reset = 1'b0;

    // 8-bit instance: 0xF0, F4, F8, FC, then wraps to 00
    for (int k = 0; k < 5; k++) begin
      #1;
      ev = 8'hF0 + 8'(k * 4);
      chk("wrap_pc8", 32'(pc8), 32'(ev));
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle takes effect without a clock edge
    #3 Proc_reset = 1'b1;
    #1 chk("async_rst_pc", pc_o, 32'h100);
    model_reset();
    @(posedge clk);
    #2 Proc_reset = 1'b0;

    repeat (2) step(idle());                        // 0x104, 0x108

    s = idle(); s.smode = 1; s.sreq = 1;            // held step request: one advance
    repeat (5) step(s);
    s.sreq = 0; step(s);

    s = idle(); s.stall = 1; s.br = 1; s.bt = 32'h300; step(s);   // hold
    s = idle(); s.stall = 1; s.trap = 1; s.tv = 32'h80; step(s);  // 0x80

    s = idle(); s.br = 1; s.bt = 32'h10; step(s);
    for (int i = 1; i <= 5; i++) begin              // calls at 0x10..0x50
      s = idle(); s.call = 1; s.br = 1;
      s.bt = (i == 5) ? 32'h1000 : 32'(16 * (i + 1));
      step(s);
    end
    s = idle(); s.ret = 1;
    repeat (4) step(s);                             // 0x54, 0x44, 0x34, 0x24
    s = idle(); s.ret = 1; s.bt = 32'h200; step(s); // empty ret -> 0x200
    s = idle(); s.call = 1; s.br = 1; s.bt = 32'h60; step(s);
    s = idle(); s.call = 1; s.ret = 1; step(s);     // -> 0x204, top 0x64
    s = idle(); s.ret = 1; step(s);                 // -> 0x64

    s = idle(); s.br = 1; s.bt = 32'h103; step(s);  // 0x100 + misalign
    step(idle());
    s = idle(); s.rst = 1; step(s);                 // synchronous reset
    step(idle());

    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.run   = ($urandom_range(0, 9) != 0);
      s.smode = ($urandom_range(0, 5) == 0);
      s.sreq  = $urandom_range(0, 1) != 0;
      s.stall = ($urandom_range(0, 4) == 0);
      s.br    = ($urandom_range(0, 3) == 0);
      s.call  = ($urandom_range(0, 3) == 0);
      s.ret   = ($urandom_range(0, 3) == 0);
      s.trap  = ($urandom_range(0, 19) == 0);
      s.rst   = ($urandom_range(0, 79) == 0);
      s.bt    = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      s.tv    = $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      step(s);
    end

    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
